// File: rtl/fetch_flow_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_flow_controller_pkg
// Description : Shared state encodings and default parameters for the
//               instruction fetch flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_flow_controller_pkg;

    localparam int c_DEFAULT_MAX_OUTSTANDING = 4;
    localparam int c_DEFAULT_PC_STEP         = 4;
    localparam int c_COUNT_WIDTH             = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetchState_t;

endpackage
`default_nettype wire

// File: rtl/fetch_flow_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_flow_controller
// Description : Issues sequential instruction fetches under a credit limit,
//               forwards in-order returns and discards stale ones on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_flow_controller
    import fetch_flow_controller_pkg::*;
#(
    parameter int P_MAX_OUTSTANDING = c_DEFAULT_MAX_OUTSTANDING,
    parameter int P_PC_STEP         = c_DEFAULT_PC_STEP
)(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREDIRECT_VALID,
    input  logic [31:0] iREDIRECT_PC,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_LOCK,
    input  logic        iMEM_VALID,
    output logic        oBUF_INST_VALID,
    output logic [31:0] oBUF_PC,
    output logic        oBUF_FREE_REFRESH,
    input  logic        iBUF_FETCH_STOP,
    input  logic        iBUF_LOCK,
    output logic [2:0]  oOUTSTANDING
);

    localparam logic [c_COUNT_WIDTH-1:0] c_MAX_OUT = 3'(P_MAX_OUTSTANDING);
    localparam logic [31:0]              c_STEP    = 32'(P_PC_STEP);

    fetchState_t                r_state;
    fetchState_t                w_stateNext;
    logic [31:0]                r_fetchPc, w_fetchPcNext;
    logic [31:0]                r_retPc, w_retPcNext;
    logic [c_COUNT_WIDTH-1:0]   r_outstanding, w_outstandingNext;
    logic [c_COUNT_WIDTH-1:0]   r_discard, w_discardNext;
    logic                       r_refresh, w_refreshNext;

    logic                       w_validRet;
    logic                       w_creditOk;
    logic                       w_memReq;
    logic                       w_accept;
    logic                       w_forward;
    logic [c_COUNT_WIDTH-1:0]   w_remaining;

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_state       <= ST_IDLE;
            r_fetchPc     <= '0;
            r_retPc       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_refresh     <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_fetchPc     <= w_fetchPcNext;
            r_retPc       <= w_retPcNext;
            r_outstanding <= w_outstandingNext;
            r_discard     <= w_discardNext;
            r_refresh     <= w_refreshNext;
        end
    end

    always_comb begin
        // A return with nothing in flight is a protocol error and is ignored
        w_validRet  = iMEM_VALID && (r_outstanding != '0);
        w_creditOk  = (r_outstanding < c_MAX_OUT) ||
                      ((r_outstanding == c_MAX_OUT) && w_validRet);
        w_memReq    = (r_state == ST_FETCH) && !iBUF_FETCH_STOP && !iBUF_LOCK &&
                      !iREDIRECT_VALID && w_creditOk;
        w_accept    = w_memReq && !iMEM_LOCK;
        w_forward   = (r_state == ST_FETCH) && w_validRet;
        w_remaining = r_outstanding - {{(c_COUNT_WIDTH-1){1'b0}}, w_validRet};

        w_stateNext       = r_state;
        w_fetchPcNext     = w_accept  ? r_fetchPc + c_STEP : r_fetchPc;
        w_retPcNext       = w_forward ? r_retPc + c_STEP   : r_retPc;
        w_outstandingNext = r_outstanding + {{(c_COUNT_WIDTH-1){1'b0}}, w_accept}
                                          - {{(c_COUNT_WIDTH-1){1'b0}}, w_validRet};
        w_discardNext     = r_discard;
        w_refreshNext     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (iREDIRECT_VALID) begin
                    w_stateNext   = ST_FETCH;
                    w_fetchPcNext = iREDIRECT_PC;
                    w_retPcNext   = iREDIRECT_PC;
                end
            end
            ST_FETCH, ST_DRAIN: begin
                if (iREDIRECT_VALID) begin
                    // Everything still in flight after this cycle is stale
                    w_refreshNext = 1'b1;
                    w_fetchPcNext = iREDIRECT_PC;
                    w_retPcNext   = iREDIRECT_PC;
                    w_discardNext = w_remaining;
                    w_stateNext   = (w_remaining != '0) ? ST_DRAIN : ST_FETCH;
                end else if (r_state == ST_DRAIN) begin
                    if (w_validRet && (r_discard != '0)) begin
                        w_discardNext = r_discard - 1'b1;
                    end
                    if (r_discard == '0) begin
                        w_stateNext = ST_FETCH;
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign oMEM_REQ          = inRESET && w_memReq;
    assign oMEM_ADDR         = inRESET ? r_fetchPc : 32'h0;
    assign oBUF_INST_VALID   = inRESET && w_forward;
    assign oBUF_PC           = inRESET ? r_retPc : 32'h0;
    assign oOUTSTANDING      = inRESET ? r_outstanding : 3'd0;
    assign oBUF_FREE_REFRESH = r_refresh;

endmodule
`default_nettype wire

// File: tb/tb_fetch_flow_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_flow_controller
// Description : Self-checking bench for fetch_flow_controller with directed
//               scenarios and a randomized run against an in-flight-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_flow_controller;

    localparam int MAXO = 4;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        redirV = 1'b0;
    logic [31:0] redirPc = 32'h0;
    logic        memLock = 1'b0;
    logic        memValid = 1'b0;
    logic        fetchStop = 1'b0;
    logic        bufLock = 1'b0;
    logic        memReq, instValid, refresh;
    logic [31:0] memAddr, bufPc;
    logic [2:0]  outCnt;

    int errors = 0;
    int checks = 0;

    fetch_flow_controller #(.P_MAX_OUTSTANDING(MAXO), .P_PC_STEP(STEP)) dut (
        .iCLOCK(clk), .inRESET(rstN),
        .iREDIRECT_VALID(redirV), .iREDIRECT_PC(redirPc),
        .oMEM_REQ(memReq), .oMEM_ADDR(memAddr), .iMEM_LOCK(memLock),
        .iMEM_VALID(memValid), .oBUF_INST_VALID(instValid), .oBUF_PC(bufPc),
        .oBUF_FREE_REFRESH(refresh), .iBUF_FETCH_STOP(fetchStop),
        .iBUF_LOCK(bufLock), .oOUTSTANDING(outCnt)
    );

    always #5 clk = ~clk;

    // Reference model: live requests queued by PC, stale ones only counted
    logic [31:0] mLive[$];
    int          mStale = 0;
    bit          mActive = 0;
    bit          mSettle = 0;
    bit          mRefresh = 0;
    logic [31:0] mFetch = 32'h0;

    bit          eReq, eInst, eRet;
    logic [31:0] eAddr, ePc;
    logic [2:0]  eOut;

    task automatic model_eval();
        int total = mStale + mLive.size();
        bit busy = (mStale > 0) || mSettle;
        eRet  = memValid && (total > 0);
        eReq  = rstN && mActive && !busy && !fetchStop && !bufLock && !redirV &&
                ((total < MAXO) || ((total == MAXO) && eRet));
        eInst = rstN && mActive && !busy && eRet;
        ePc   = eInst ? mLive[0] : 32'h0;
        eAddr = rstN ? mFetch : 32'h0;
        eOut  = rstN ? 3'(total) : 3'd0;
    endtask

    task automatic model_update();
        if (!rstN) begin
            mLive.delete();
            mStale = 0; mActive = 0; mSettle = 0; mRefresh = 0; mFetch = 32'h0;
        end else begin
            bit acc = eReq && !memLock;
            bit wasDrain = (mStale > 0);
            mRefresh = redirV && mActive;
            if (eRet) begin
                if (mStale > 0) mStale--;
                else void'(mLive.pop_front());
            end
            if (acc) begin
                mLive.push_back(mFetch);
                mFetch = mFetch + 32'(STEP);
            end
            mSettle = 0;
            if (redirV) begin
                mFetch = redirPc;
                if (mActive) begin
                    mStale += mLive.size();
                    mLive.delete();
                end
                mActive = 1;
            end else if (wasDrain && mStale == 0) begin
                mSettle = 1;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_eval();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_for_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (memReq === 1'b1) begin
                ok = 1;
                return;
            end
            advance();
        end
    endtask

    task automatic fill_to(input int target);
        for (int i = 0; i < 20; i++) begin
            settle();
            if (outCnt === 3'(target)) return;
            advance();
        end
    endtask

    task automatic test_reset();
        rstN = 0; redirV = 1; redirPc = 32'hDEAD_BEE0; memValid = 1;
        settle();
        checks++;
        if (memReq !== 1'b0 || memAddr !== 32'h0 || instValid !== 1'b0 ||
            bufPc !== 32'h0 || outCnt !== 3'd0)
            begin errors++; $display("FAIL reset_outputs: req=%b addr=%h inst=%b pc=%h out=%0d, expected all zero", memReq, memAddr, instValid, bufPc, outCnt); end
        advance(); advance();
        checks++;
        if (refresh !== 1'b0) begin errors++; $display("FAIL reset_refresh: got %b expected 0", refresh); end
        rstN = 1; redirV = 0; memValid = 0;
        settle();
        checks++;
        if (memReq !== 1'b0 || outCnt !== 3'd0) begin errors++; $display("FAIL idle_after_reset: req=%b out=%0d expected 0/0", memReq, outCnt); end
    endtask

    task automatic test_sequential_fetch();
        redirV = 1; redirPc = 32'h1000;
        settle();
        checks++;
        if (memReq !== 1'b0) begin errors++; $display("FAIL idle_redirect_req: got %b expected 0", memReq); end
        advance();
        redirV = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++;
            if (memReq !== 1'b1 || memAddr !== 32'h1000 + 32'(i * 4))
                begin errors++; $display("FAIL seq_addr[%0d]: req=%b addr=%h expected 1/%h", i, memReq, memAddr, 32'h1000 + 32'(i * 4)); end
            advance();
        end
        settle();
        checks++;
        if (memReq !== 1'b0 || outCnt !== 3'd4) begin errors++; $display("FAIL credit_block: req=%b out=%0d expected 0/4", memReq, outCnt); end
        checks++;
        if (refresh !== 1'b0) begin errors++; $display("FAIL idle_no_refresh: got %b expected 0", refresh); end
        memValid = 1;
        settle();
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h1010) begin errors++; $display("FAIL fifth_req: req=%b addr=%h expected 1/00001010", memReq, memAddr); end
        checks++;
        if (instValid !== 1'b1 || bufPc !== 32'h1000) begin errors++; $display("FAIL first_return: inst=%b pc=%h expected 1/00001000", instValid, bufPc); end
        advance();
        memValid = 0;
        settle();
        checks++;
        if (outCnt !== 3'd4) begin errors++; $display("FAIL net_zero: out=%0d expected 4", outCnt); end
    endtask

    task automatic test_redirect_drain();
        bit ok;
        fetchStop = 1; memValid = 1;
        settle();
        checks++;
        if (instValid !== 1'b1 || bufPc !== 32'h1004) begin errors++; $display("FAIL pre_drain_return: inst=%b pc=%h expected 1/00001004", instValid, bufPc); end
        advance();
        memValid = 0; redirV = 1; redirPc = 32'h2000; fetchStop = 0;
        settle();
        checks++;
        if (memReq !== 1'b0) begin errors++; $display("FAIL redirect_suppress: req=%b expected 0", memReq); end
        advance();
        redirV = 0; memValid = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (instValid !== 1'b0 || memReq !== 1'b0) begin errors++; $display("FAIL drain_drop[%0d]: inst=%b req=%b expected 0/0", i, instValid, memReq); end
            checks++;
            if (refresh !== (i == 0)) begin errors++; $display("FAIL refresh_pulse[%0d]: got %b expected %b", i, refresh, i == 0); end
            checks++;
            if (outCnt !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d]: out=%0d expected %0d", i, outCnt, 3 - i); end
            advance();
        end
        memValid = 0;
        wait_for_req(ok);
        checks++;
        if (!ok || memAddr !== 32'h2000) begin errors++; $display("FAIL resume_addr: ok=%b addr=%h expected 1/00002000", ok, memAddr); end
        advance();
        fetchStop = 1; memValid = 1;
        settle();
        checks++;
        if (instValid !== 1'b1 || bufPc !== 32'h2000) begin errors++; $display("FAIL first_after_redirect: inst=%b pc=%h expected 1/00002000", instValid, bufPc); end
        advance();
        memValid = 0;
    endtask

    task automatic test_redirect_in_drain();
        bit ok;
        fetchStop = 0;
        fill_to(4);
        checks++;
        if (outCnt !== 3'd4) begin errors++; $display("FAIL fill4: out=%0d expected 4", outCnt); end
        fetchStop = 1; redirV = 1; redirPc = 32'h3000;
        advance();
        redirV = 0; memValid = 1;
        advance(); advance();
        memValid = 0;
        settle();
        checks++;
        if (outCnt !== 3'd2 || instValid !== 1'b0) begin errors++; $display("FAIL discard_two: out=%0d inst=%b expected 2/0", outCnt, instValid); end
        redirV = 1; redirPc = 32'h4000;
        advance();
        redirV = 0;
        settle();
        checks++;
        if (refresh !== 1'b1 || outCnt !== 3'd2) begin errors++; $display("FAIL second_refresh: refresh=%b out=%0d expected 1/2", refresh, outCnt); end
        memValid = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (instValid !== 1'b0) begin errors++; $display("FAIL redrain_drop[%0d]: inst=%b expected 0", i, instValid); end
            advance();
        end
        memValid = 0; fetchStop = 0;
        wait_for_req(ok);
        checks++;
        if (!ok || memAddr !== 32'h4000) begin errors++; $display("FAIL newest_pc: ok=%b addr=%h expected 1/00004000", ok, memAddr); end
        advance();
        fetchStop = 1; memValid = 1;
        settle();
        checks++;
        if (instValid !== 1'b1 || bufPc !== 32'h4000) begin errors++; $display("FAIL newest_return: inst=%b pc=%h expected 1/00004000", instValid, bufPc); end
        advance();
        memValid = 0;
    endtask

    task automatic test_fetch_stop();
        fetchStop = 0;
        fill_to(3);
        fetchStop = 1;
        for (int i = 0; i < 10; i++) begin
            memValid = (i % 3 == 0);
            settle();
            checks++;
            if (memReq !== 1'b0) begin errors++; $display("FAIL stop_no_req[%0d]: req=%b expected 0", i, memReq); end
            checks++;
            if (instValid !== eInst || (eInst && bufPc !== ePc)) begin errors++; $display("FAIL stop_forward[%0d]: inst=%b pc=%h expected %b/%h", i, instValid, bufPc, eInst, ePc); end
            advance();
        end
        memValid = 0;
    endtask

    task automatic test_wrap();
        bit ok;
        redirV = 1; redirPc = 32'hFFFF_FFFC; fetchStop = 0;
        advance();
        redirV = 0;
        wait_for_req(ok);
        checks++;
        if (!ok || memAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: ok=%b addr=%h expected 1/fffffffc", ok, memAddr); end
        memLock = 0;
        advance();
        memLock = 1;
        settle();
        checks++;
        if (memAddr !== 32'h0 || memReq !== 1'b1) begin errors++; $display("FAIL wrap_zero: addr=%h req=%b expected 00000000/1", memAddr, memReq); end
        advance();
        settle();
        checks++;
        if (memAddr !== 32'h0 || outCnt !== 3'd1) begin errors++; $display("FAIL lock_hold: addr=%h out=%0d expected 00000000/1", memAddr, outCnt); end
        memLock = 0;
    endtask

    task automatic test_full_credit();
        fill_to(4);
        memValid = 1;
        settle();
        checks++;
        if (memReq !== 1'b1 || instValid !== 1'b1) begin errors++; $display("FAIL full_accept: req=%b inst=%b expected 1/1", memReq, instValid); end
        advance();
        memValid = 0;
        settle();
        checks++;
        if (outCnt !== 3'd4) begin errors++; $display("FAIL full_hold: out=%0d expected 4", outCnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            redirV    = ($urandom_range(0, 15) == 0);
            redirPc   = $urandom;
            memValid  = ($urandom_range(0, 1) == 1);
            memLock   = ($urandom_range(0, 3) == 0);
            fetchStop = ($urandom_range(0, 7) == 0);
            bufLock   = ($urandom_range(0, 7) == 0);
            settle();
            checks++;
            if (memReq !== eReq || memAddr !== eAddr) begin errors++; $display("FAIL rnd_req[%0d]: req=%b addr=%h expected %b/%h", i, memReq, memAddr, eReq, eAddr); end
            checks++;
            if (instValid !== eInst || (eInst && bufPc !== ePc)) begin errors++; $display("FAIL rnd_fwd[%0d]: inst=%b pc=%h expected %b/%h", i, instValid, bufPc, eInst, ePc); end
            checks++;
            if (outCnt !== eOut || refresh !== mRefresh) begin errors++; $display("FAIL rnd_state[%0d]: out=%0d refresh=%b expected %0d/%b", i, outCnt, refresh, eOut, mRefresh); end
            advance();
        end
        redirV = 0; memValid = 0; memLock = 0; fetchStop = 0; bufLock = 0;
    endtask

    task automatic test_reset_midflight();
        fill_to(2);
        rstN = 0;
        settle();
        checks++;
        if (memReq !== 1'b0 || outCnt !== 3'd0 || memAddr !== 32'h0) begin errors++; $display("FAIL mid_reset_outputs: req=%b out=%0d addr=%h expected 0/0/0", memReq, outCnt, memAddr); end
        advance();
        rstN = 1;
        settle();
        checks++;
        if (memReq !== 1'b0 || outCnt !== 3'd0 || refresh !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: req=%b out=%0d refresh=%b expected 0/0/0", memReq, outCnt, refresh); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential_fetch();
        test_redirect_drain();
        test_redirect_in_drain();
        test_fetch_stop();
        test_wrap();
        test_full_credit();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
